// File: rtl/axi_master_port_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) shared by the initiator and any responder.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

interface axi_master_port_if;
    logic [`AXI_ID_BITS-1:0] AWID;
    logic [31:0]             AWADDR;
    logic [3:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [31:0]             WDATA;
    logic [3:0]              WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [`AXI_ID_BITS-1:0] BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [`AXI_ID_BITS-1:0] ARID;
    logic [31:0]             ARADDR;
    logic [3:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [`AXI_ID_BITS-1:0] RID;
    logic [31:0]             RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_master_port.sv
// Single-outstanding AXI4 initiator: one-beat writes and 1..16-beat INCR reads
// issued from a simple core-side request, read beats streamed back as they land.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

// Every AXI channel uses valid/ready: a transfer happens on a rising clk edge
// where both are high; a raised valid is held with stable payload until then.
module axi_master_port #(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [3:0]  req_len,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        resp_err,
    output logic [2:0]  state_dbg,
    axi_master_port_if.master axi
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RA   = 3'd3,
        RD   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  len_q;
    logic        aw_pend, w_pend;
    logic [3:0]  cnt;
    logic        sticky;

    logic accept;
    logic b_fire;
    logic r_fire;
    logic beat_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // The done cycle still counts as busy so req_ready returns one cycle later.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        b_fire    = 1'b0;
        r_fire    = 1'b0;
        beat_err  = 1'b0;
        case (state)
            IDLE: begin
                accept = req && !done;
                if (accept) state_nxt = req_we ? WR : RA;
            end
            WR: begin
                if ((!aw_pend || axi.AWREADY) && (!w_pend || axi.WREADY))
                    state_nxt = WB;
            end
            WB: begin
                b_fire = axi.BVALID;
                if (axi.BVALID) state_nxt = IDLE;
            end
            RA: begin
                if (axi.ARREADY) state_nxt = RD;
            end
            RD: begin
                r_fire   = axi.RVALID;
                beat_err = (axi.RRESP != 2'b00) || (axi.RID != MASTER_ID) ||
                           ((cnt == len_q) && !axi.RLAST);
                if (axi.RVALID && axi.RLAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            len_q       <= '0;
            aw_pend     <= 1'b0;
            w_pend      <= 1'b0;
            cnt         <= '0;
            sticky      <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            resp_err    <= 1'b0;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                len_q   <= req_len;
                aw_pend <= req_we;
                w_pend  <= req_we;
                cnt     <= '0;
                sticky  <= 1'b0;
            end
            if (state == WR) begin
                if (axi.AWREADY) aw_pend <= 1'b0;
                if (axi.WREADY)  w_pend  <= 1'b0;
            end
            if (b_fire) begin
                done     <= 1'b1;
                resp_err <= (axi.BRESP != 2'b00) || (axi.BID != MASTER_ID);
            end
            if (r_fire) begin
                rdata       <= axi.RDATA;
                rdata_valid <= 1'b1;
                if (cnt != 4'd15) cnt <= cnt + 4'd1;
                if (axi.RLAST) begin
                    done     <= 1'b1;
                    resp_err <= sticky || beat_err || (cnt != len_q);
                end else begin
                    sticky <= sticky || beat_err;
                end
            end
        end
    end

    assign req_ready = (state == IDLE) && !done;
    assign state_dbg = state;

    // AXI outputs depend only on registers and state, never on AXI inputs.
    assign axi.AWID    = (state == WR) ? MASTER_ID : '0;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = (state == WR) && aw_pend;

    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = (state == WR) && w_pend;
    assign axi.WLAST   = (state == WR) && w_pend;

    assign axi.BREADY  = (state == WB);

    assign axi.ARID    = (state == RA) ? MASTER_ID : '0;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = (state == RA);

    assign axi.RREADY  = (state == RD);

endmodule

// File: tb/tb_axi_master_port.sv
// Directed bench for axi_master_port: scripted AXI responder, scoreboard queues
// for read beats and done/resp_err, cycle-level timing checks.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module tb_axi_master_port;
    localparam logic [`AXI_ID_BITS-1:0] MID = 4'h3;
    localparam logic [`AXI_ID_BITS-1:0] BAD = 4'h5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [3:0]  req_len = '0;
    logic        req_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        resp_err;
    logic [2:0]  state_dbg;

    axi_master_port_if bus();

    axi_master_port #(.MASTER_ID(MID)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_len(req_len), .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
        .resp_err(resp_err), .state_dbg(state_dbg), .axi(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          aw_hs = 0;
    int          w_hs = 0;
    int          aw0, w0;
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    logic [31:0] mon_exp;
    logic        mon_err;

    always @(posedge clk) begin
        if (bus.AWVALID && bus.AWREADY) aw_hs <= aw_hs + 1;
        if (bus.WVALID && bus.WREADY)   w_hs  <= w_hs + 1;
    end

    // Monitor: every presented read beat / done is matched against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (rdata_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rdata_unexpected: got %h with nothing expected", rdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rdata !== mon_exp) begin
                        failures++;
                        $display("FAIL rdata: got %h expected %h", rdata, mon_exp);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_err_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: resp_err=%0b with nothing expected", resp_err);
                end else begin
                    mon_err = exp_err_q.pop_front();
                    if (resp_err !== mon_err) begin
                        failures++;
                        $display("FAIL resp_err: got %0b expected %0b", resp_err, mon_err);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [3:0] len);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", {31'd0, req_ready}, 32'd1);
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_wstrb = wstrb; req_len = len;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic b_resp(input logic [`AXI_ID_BITS-1:0] id, input logic [1:0] resp);
        int n = 0;
        while (!bus.BREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bready_wait", {31'd0, bus.BREADY}, 32'd1);
        bus.BVALID = 1'b1; bus.BID = id; bus.BRESP = resp;
        @(negedge clk);
        bus.BVALID = 1'b0;
    endtask

    task automatic r_burst(input int nbeats, input logic [31:0] base, input int last_at,
                           input int err_at, input logic [`AXI_ID_BITS-1:0] id);
        int n = 0;
        while (!bus.RREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rready_wait", {31'd0, bus.RREADY}, 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            bus.RVALID = 1'b1;
            bus.RDATA  = base + i;
            bus.RLAST  = (i == last_at);
            bus.RRESP  = (i == err_at) ? 2'b10 : 2'b00;
            bus.RID    = id;
            @(negedge clk);
        end
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.ARREADY = 1'b0;
        bus.BVALID = 1'b0; bus.BID = '0; bus.BRESP = '0;
        bus.RVALID = 1'b0; bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 1'b0;

        // Reset state
        #12;
        check("rst_awvalid", {31'd0, bus.AWVALID}, 32'd0);
        check("rst_wvalid", {31'd0, bus.WVALID}, 32'd0);
        check("rst_arvalid", {31'd0, bus.ARVALID}, 32'd0);
        check("rst_bready", {31'd0, bus.BREADY}, 32'd0);
        check("rst_rready", {31'd0, bus.RREADY}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_araddr", bus.ARADDR, 32'd0);
        check("rst_arlen", {28'd0, bus.ARLEN}, 32'd0);
        check("rst_arid", {28'd0, bus.ARID}, 32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait write
        bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
        exp_err_q.push_back(1'b0);
        issue(1'b1, 32'h1001_0100, 32'h0000_0001, 4'hF, 4'd0);
        check("w1_awvalid", {31'd0, bus.AWVALID}, 32'd1);
        check("w1_wvalid", {31'd0, bus.WVALID}, 32'd1);
        check("w1_awlen", {28'd0, bus.AWLEN}, 32'd0);
        check("w1_wlast", {31'd0, bus.WLAST}, 32'd1);
        check("w1_awaddr", bus.AWADDR, 32'h1001_0100);
        check("w1_wdata", bus.WDATA, 32'h0000_0001);
        check("w1_wstrb", {28'd0, bus.WSTRB}, 32'hF);
        check("w1_awsize", {29'd0, bus.AWSIZE}, 32'd2);
        check("w1_awburst", {30'd0, bus.AWBURST}, 32'd1);
        check("w1_awid", {28'd0, bus.AWID}, {28'd0, MID});
        check("w1_req_ready_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("w1_awvalid_drop", {31'd0, bus.AWVALID}, 32'd0);
        check("w1_wvalid_drop", {31'd0, bus.WVALID}, 32'd0);
        check("w1_bready", {31'd0, bus.BREADY}, 32'd1);
        b_resp(MID, 2'b00);
        check("w1_done_t3", {31'd0, done}, 32'd1);
        check("w1_req_ready_at_done", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("w1_req_ready_after", {31'd0, req_ready}, 32'd1);
        check("w1_done_single", {31'd0, done}, 32'd0);

        // Write with AWREADY held low for 3 cycles
        bus.AWREADY = 1'b0;
        aw0 = aw_hs; w0 = w_hs;
        exp_err_q.push_back(1'b0);
        issue(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'h3, 4'd0);
        check("w2_both_valid", {30'd0, bus.AWVALID, bus.WVALID}, 32'd3);
        @(negedge clk);
        check("w2_wvalid_dropped", {31'd0, bus.WVALID}, 32'd0);
        check("w2_awvalid_c2", {31'd0, bus.AWVALID}, 32'd1);
        @(negedge clk);
        check("w2_awvalid_c3", {31'd0, bus.AWVALID}, 32'd1);
        @(negedge clk);
        check("w2_awvalid_c4", {31'd0, bus.AWVALID}, 32'd1);
        bus.AWREADY = 1'b1;
        @(negedge clk);
        check("w2_awvalid_drop", {31'd0, bus.AWVALID}, 32'd0);
        b_resp(MID, 2'b00);
        check("w2_done", {31'd0, done}, 32'd1);
        check("w2_aw_count", aw_hs - aw0, 32'd1);
        check("w2_w_count", w_hs - w0, 32'd1);

        // 4-beat read, zero wait
        bus.ARREADY = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        exp_err_q.push_back(1'b0);
        issue(1'b0, 32'h2000_0000, 32'd0, 4'd0, 4'd3);
        check("r1_arvalid", {31'd0, bus.ARVALID}, 32'd1);
        check("r1_arlen", {28'd0, bus.ARLEN}, 32'd3);
        check("r1_araddr", bus.ARADDR, 32'h2000_0000);
        check("r1_arsize", {29'd0, bus.ARSIZE}, 32'd2);
        check("r1_arburst", {30'd0, bus.ARBURST}, 32'd1);
        check("r1_arid", {28'd0, bus.ARID}, {28'd0, MID});
        @(negedge clk);
        check("r1_arvalid_drop", {31'd0, bus.ARVALID}, 32'd0);
        r_burst(4, 32'hA0, 3, -1, MID);
        check("r1_done_t6", {31'd0, done}, 32'd1);

        // Early RLAST on beat 2 of 4
        for (int i = 0; i < 2; i++) exp_q.push_back(32'hB0 + i);
        exp_err_q.push_back(1'b1);
        issue(1'b0, 32'h2000_0100, 32'd0, 4'd0, 4'd3);
        r_burst(2, 32'hB0, 1, -1, MID);
        check("r2_done", {31'd0, done}, 32'd1);

        // SLVERR on beat 1
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0 + i);
        exp_err_q.push_back(1'b1);
        issue(1'b0, 32'h2000_0200, 32'd0, 4'd0, 4'd3);
        r_burst(4, 32'hC0, 3, 0, MID);
        check("r3_done", {31'd0, done}, 32'd1);

        // Overrun: len=1 but three beats before RLAST
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hD0 + i);
        exp_err_q.push_back(1'b1);
        issue(1'b0, 32'h2000_0300, 32'd0, 4'd0, 4'd1);
        r_burst(3, 32'hD0, 2, -1, MID);
        check("r4_done", {31'd0, done}, 32'd1);

        // Single-beat read, clean, then one with a wrong RID
        exp_q.push_back(32'hE0);
        exp_err_q.push_back(1'b0);
        issue(1'b0, 32'h2000_0400, 32'd0, 4'd0, 4'd0);
        r_burst(1, 32'hE0, 0, -1, MID);
        check("r5_done", {31'd0, done}, 32'd1);
        exp_q.push_back(32'hE8);
        exp_err_q.push_back(1'b1);
        issue(1'b0, 32'h2000_0404, 32'd0, 4'd0, 4'd0);
        r_burst(1, 32'hE8, 0, -1, BAD);
        check("r6_done", {31'd0, done}, 32'd1);

        // Wrong BID with req held high throughout
        bus.AWREADY = 1'b0;
        exp_err_q.push_back(1'b1);
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 32'h1000_0080; req_wdata = 32'h1234_5678;
        req_wstrb = 4'hF;
        @(negedge clk);
        check("w3_state_wr", {29'd0, state_dbg}, 32'd1);
        check("w3_req_ready_wr", {31'd0, req_ready}, 32'd0);
        bus.AWREADY = 1'b1;
        @(negedge clk);
        check("w3_state_wb", {29'd0, state_dbg}, 32'd2);
        check("w3_req_ready_wb", {31'd0, req_ready}, 32'd0);
        b_resp(BAD, 2'b00);
        req = 1'b0;
        check("w3_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("w3_idle", {29'd0, state_dbg}, 32'd0);

        // Stray B/R while idle are not accepted
        bus.BVALID = 1'b1; bus.RVALID = 1'b1; bus.RLAST = 1'b1;
        #1;
        check("idle_bready", {31'd0, bus.BREADY}, 32'd0);
        check("idle_rready", {31'd0, bus.RREADY}, 32'd0);
        @(negedge clk);
        bus.BVALID = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0;
        @(negedge clk);
        check("idle_no_done", {31'd0, done}, 32'd0);

        // Reset in the middle of a 4-beat read
        for (int i = 0; i < 2; i++) exp_q.push_back(32'hF0 + i);
        issue(1'b0, 32'h2000_0500, 32'd0, 4'd0, 4'd3);
        r_burst(2, 32'hF0, -1, -1, MID);
        check("rr_rready_before", {31'd0, bus.RREADY}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rr_rready_rst", {31'd0, bus.RREADY}, 32'd0);
        check("rr_arvalid_rst", {31'd0, bus.ARVALID}, 32'd0);
        check("rr_state_rst", {29'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rr_req_ready", {31'd0, req_ready}, 32'd1);
        check("rr_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("exp_err_q_empty", exp_err_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_master_port.md
# axi_master_port

Single-outstanding AXI4 initiator that turns a simple core-side request (register write or burst read) into AXI master channel traffic. It sits between a CPU/DMA-side requester and the bus interconnect. It drives the same AW/W/B/AR/R channels that the peripheral wrappers (WDT, DRAM, ROM) respond to. Writes are single-beat INCR bursts. Reads are INCR bursts of 1 to 16 beats, and read data is streamed back beat by beat.

## Interface
Parameters:
- MASTER_ID, default 4'd0, value driven on AWID/ARID; also the value expected on BID/RID.

Ports:
- clk  in  1  single clock
- rst  in  1  reset; asynchronous, active-low
- req  in  1  request valid; accepted when req_ready=1
- req_ready  out  1  high only in IDLE
- req_we  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- req_len  in  4  read beats minus 1; ignored for writes
- rdata  out  32  read beat data
- rdata_valid  out  1  one-cycle pulse per read beat
- done  out  1  one-cycle pulse at transaction end
- resp_err  out  1  valid with done; 1 = error
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  `AXI_ID_BITS/32/4/3/2/1
- AWREADY  in  1
- WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1
- WREADY  in  1
- BID/BRESP/BVALID  in  `AXI_ID_BITS/2/1; BREADY out 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  `AXI_ID_BITS/32/4/3/2/1
- ARREADY  in  1
- RID/RDATA/RRESP/RLAST/RVALID  in  `AXI_ID_BITS/32/2/1/1; RREADY out 1

## Operation
- States: IDLE, WR (AW+W issue), WB (wait B), RA (AR issue), RD (receive R).
- IDLE: req_ready=1. When req=1, latch addr, wdata, wstrb, len and we. Then go to WR if req_we, else to RA.
- WR behaviour:
  - AWVALID and WVALID rise together.
  - Each channel drops after its own handshake; the two handshakes may complete in any order or in the same cycle.
  - Move to WB once both handshakes are done.
  - AW fields: AWLEN=0, AWSIZE=3'b010, AWBURST=2'b01, WLAST=1 while WVALID.
- WB: BREADY=1. On BVALID, set resp_err = (BRESP!=OKAY) | (BID!=MASTER_ID), pulse done, return to IDLE.
- RA: ARVALID=1 with ARLEN=latched len, ARSIZE=3'b010, ARBURST=2'b01. On ARREADY go to RD.
- RD behaviour:
  - RREADY=1.
  - Each RVALID beat registers RDATA to rdata and pulses rdata_valid.
  - A 4-bit beat counter increments per beat.
  - A sticky error sets if RRESP!=OKAY or RID!=MASTER_ID.
  - On the RLAST beat: done pulses together with the final rdata_valid, resp_err = sticky | (counter!=len), then IDLE.
- Beats arriving after counter==len without RLAST: counter saturates at 15, sticky error set, still wait for RLAST.
- BVALID in a non-WB state and RVALID in a non-RD state are ignored (BREADY/RREADY=0).
- req while busy is not accepted; the requester holds it.

## Timing
- Reset (asynchronous, rst=0): state=IDLE. All VALID/READY outputs, done, rdata_valid and resp_err are 0. rdata=0, counter=0, address/ID/len outputs=0.
- Reset mid-transaction: valids drop immediately; no done is issued.
- All AXI outputs come from registers or from decode of state only; no combinational path from any AXI input to any AXI output.
- Write latency: req accepted at edge T; AWVALID/WVALID high in cycle T+1. With zero-wait responder: AW/W handshake at T+1, BVALID at T+2, done at T+3.
- Read latency: ARVALID high at T+1; first R beat at earliest T+2; its rdata_valid at T+3. An N-beat zero-wait read gives done at T+2+N.
- req_ready returns high in the cycle after done.

## Test plan
- Write 0x0000_0001 to 0x1001_0100, wstrb=4'hF, zero-wait responder -> AW/W both seen at T+1 with AWLEN=0 and WLAST=1; done at T+3; resp_err=0.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle; AWVALID held 4 cycles; exactly one AW and one W handshake; single done.
- Read with req_len=3, responder returns 0xA0..0xA3 with RLAST on beat 4 -> four rdata_valid pulses carrying 0xA0..0xA3 in order; done on the 4th; resp_err=0.
- Read with req_len=3, RLAST on beat 2 -> done on beat 2; resp_err=1. A separate read with RRESP=SLVERR on beat 1 -> resp_err=1 at done.
- BID != MASTER_ID on write response -> resp_err=1; req_ready is 0 during WR/WB even with req held high.
- Assert rst=0 while in RD after 2 of 4 beats -> RREADY/ARVALID immediately 0; after release: IDLE, req_ready=1, no done pulse.
